// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin single-port CDB arbiter with registered broadcast
module cdb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int XLEN   = 32,
   parameter int TAG_W  = 5
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_FU:0]               fu_done,
   input  logic [(NUM_FU+1)*TAG_W-1:0]   fu_rob_tag,
   input  logic [(NUM_FU+1)*XLEN-1:0]    fu_value,
   input  logic [NUM_FU:0]               fu_take_branch,
   output logic [NUM_FU:0]               fu_ack,
   output logic                          cdb_valid,
   output logic [TAG_W-1:0]              cdb_rob_tag,
   output logic [XLEN-1:0]               cdb_value,
   output logic                          cdb_take_branch,
   output logic [NUM_FU:0]               dones_dbg,
   output logic [NUM_FU:0]               ack_dbg
);

   localparam int NSLOT = NUM_FU + 1;
   localparam int PTR_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   // Scan arithmetic is one bit wider than the pointer so ptr+k never overflows before wrapping.
   localparam logic [PTR_W:0]   LAST_SCAN = (PTR_W+1)'(NUM_FU);
   localparam logic [PTR_W:0]   NSLOT_SCAN = (PTR_W+1)'(NSLOT);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_FU);

   // Round-robin pointer: the slot with highest priority this cycle.
   logic [PTR_W-1:0] r_ptr;
   logic             r_cdb_valid;
   logic [TAG_W-1:0] r_cdb_rob_tag;
   logic [XLEN-1:0]  r_cdb_value;
   logic             r_cdb_take_branch;

   logic [PTR_W:0]   w_scan;
   logic             w_win_valid;
   logic [PTR_W-1:0] w_win_idx;
   logic [NUM_FU:0]  w_sel;
   logic [NUM_FU:0]  w_ack;
   logic             w_grant;
   logic [TAG_W-1:0] w_win_tag;
   logic [XLEN-1:0]  w_win_value;
   logic             w_win_branch;
   logic [PTR_W-1:0] w_ptr_next;

   // Find the first requesting slot starting at r_ptr and wrapping past NUM_FU back to 0.
   always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      w_scan      = '0;
      for (int k = 0; k < NSLOT; k++) begin
         w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
         if (w_scan > LAST_SCAN) begin
            w_scan = w_scan - NSLOT_SCAN;
         end
         if (!w_win_valid && fu_done[w_scan[PTR_W-1:0]]) begin
            w_win_valid = 1'b1;
            w_win_idx   = w_scan[PTR_W-1:0];
         end
      end
   end

   // One-hot winner decode; grants are suppressed while reset is held low.
   always_comb begin
      w_sel = '0;
      for (int j = 0; j < NSLOT; j++) begin
         w_sel[j] = w_win_valid && (w_win_idx == PTR_W'(j));
      end
      w_ack   = w_sel & {NSLOT{reset}};
      w_grant = |w_ack;
   end

   // Payload mux: the selection is one-hot, so OR-ing the gated slices picks the winner.
   always_comb begin
      w_win_tag    = '0;
      w_win_value  = '0;
      w_win_branch = 1'b0;
      for (int j = 0; j < NSLOT; j++) begin
         if (w_sel[j]) begin
            w_win_tag    = w_win_tag    | fu_rob_tag[j*TAG_W +: TAG_W];
            w_win_value  = w_win_value  | fu_value[j*XLEN +: XLEN];
            w_win_branch = w_win_branch | fu_take_branch[j];
         end
      end
   end

   // Next pointer sits just past the winner, wrapping from NUM_FU to 0.
   always_comb begin
      if (w_win_idx == LAST_IDX) begin
         w_ptr_next = '0;
      end else begin
         w_ptr_next = w_win_idx + PTR_W'(1);
      end
   end

   // Broadcast register: a grant is visible on the CDB for exactly the following cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_ptr             <= '0;
         r_cdb_valid       <= 1'b0;
         r_cdb_rob_tag     <= '0;
         r_cdb_value       <= '0;
         r_cdb_take_branch <= 1'b0;
      end else if (w_grant) begin
         r_ptr             <= w_ptr_next;
         r_cdb_valid       <= 1'b1;
         r_cdb_rob_tag     <= w_win_tag;
         r_cdb_value       <= w_win_value;
         r_cdb_take_branch <= w_win_branch;
      end else begin
         r_cdb_valid       <= 1'b0;
         r_cdb_rob_tag     <= '0;
         r_cdb_value       <= '0;
         r_cdb_take_branch <= 1'b0;
      end
   end

   assign fu_ack          = w_ack;
   assign cdb_valid       = r_cdb_valid;
   assign cdb_rob_tag     = r_cdb_rob_tag;
   assign cdb_value       = r_cdb_value;
   assign cdb_take_branch = r_cdb_take_branch;
   assign dones_dbg       = fu_done;
   assign ack_dbg         = w_ack;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

   localparam int NUM_FU = 4;
   localparam int XLEN   = 32;
   localparam int TAG_W  = 5;

   logic                        clock;
   logic                        reset;
   logic [NUM_FU:0]             fu_done;
   logic [(NUM_FU+1)*TAG_W-1:0] fu_rob_tag;
   logic [(NUM_FU+1)*XLEN-1:0]  fu_value;
   logic [NUM_FU:0]             fu_take_branch;
   logic [NUM_FU:0]             fu_ack;
   logic                        cdb_valid;
   logic [TAG_W-1:0]            cdb_rob_tag;
   logic [XLEN-1:0]             cdb_value;
   logic                        cdb_take_branch;
   logic [NUM_FU:0]             dones_dbg;
   logic [NUM_FU:0]             ack_dbg;

   int checks;
   int failures;

   cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock           (clock),
      .reset           (reset),
      .fu_done         (fu_done),
      .fu_rob_tag      (fu_rob_tag),
      .fu_value        (fu_value),
      .fu_take_branch  (fu_take_branch),
      .fu_ack          (fu_ack),
      .cdb_valid       (cdb_valid),
      .cdb_rob_tag     (cdb_rob_tag),
      .cdb_value       (cdb_value),
      .cdb_take_branch (cdb_take_branch),
      .dones_dbg       (dones_dbg),
      .ack_dbg         (ack_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Load one slot's payload.
   task automatic set_slot(input int i, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val, input logic br);
      fu_rob_tag[i*TAG_W +: TAG_W] = tag;
      fu_value[i*XLEN +: XLEN]     = val;
      fu_take_branch[i]            = br;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Pulse reset for one edge so the pointer returns to 0.
   task automatic do_reset();
      reset   = 1'b0;
      fu_done = '0;
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      fu_done = 5'b11111;
      for (int i = 0; i <= NUM_FU; i++) set_slot(i, TAG_W'(20 + i), XLEN'(200 + i), 1'b1);
      step();
      step();
      checks++; if (fu_ack !== 5'b00000) begin failures++; $display("FAIL reset_ack got=%b exp=%b", fu_ack, 5'b00000); end
      checks++; if (ack_dbg !== 5'b00000) begin failures++; $display("FAIL reset_ack_dbg got=%b exp=%b", ack_dbg, 5'b00000); end
      checks++; if (dones_dbg !== 5'b11111) begin failures++; $display("FAIL reset_dones_dbg got=%b exp=%b", dones_dbg, 5'b11111); end
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
      checks++; if (cdb_value !== 32'd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", cdb_value); end
      checks++; if (cdb_rob_tag !== 5'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", cdb_rob_tag); end
      checks++; if (cdb_take_branch !== 1'b0) begin failures++; $display("FAIL reset_branch got=%b exp=0", cdb_take_branch); end
      reset   = 1'b1;
      fu_done = '0;
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", cdb_valid); end
   endtask

   task automatic test_single();
      do_reset();
      set_slot(1, 5'd3, 32'd12, 1'b0);
      fu_done = 5'b00010;
      #1;
      checks++; if (fu_ack !== 5'b00010) begin failures++; $display("FAIL single_ack got=%b exp=%b", fu_ack, 5'b00010); end
      checks++; if (ack_dbg !== 5'b00010) begin failures++; $display("FAIL single_ack_dbg got=%b exp=%b", ack_dbg, 5'b00010); end
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%b exp=0", cdb_valid); end
      step();
      fu_done = 5'b00000;
      checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", cdb_valid); end
      checks++; if (cdb_rob_tag !== 5'd3) begin failures++; $display("FAIL single_tag got=%0d exp=3", cdb_rob_tag); end
      checks++; if (cdb_value !== 32'd12) begin failures++; $display("FAIL single_value got=%0d exp=12", cdb_value); end
      checks++; if (cdb_take_branch !== 1'b0) begin failures++; $display("FAIL single_branch got=%b exp=0", cdb_take_branch); end
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_after_valid got=%b exp=0", cdb_valid); end
      checks++; if (cdb_value !== 32'd0) begin failures++; $display("FAIL single_after_value got=%0d exp=0", cdb_value); end
   endtask

   task automatic test_contention();
      int order[6];
      logic [NUM_FU:0] exp_ack;
      order = '{0, 1, 2, 3, 4, 0};
      for (int i = 0; i <= NUM_FU; i++) set_slot(i, TAG_W'(10 + i), XLEN'(100 + i), (i % 2) == 1);
      do_reset();
      fu_done = 5'b11111;
      for (int c = 0; c < 6; c++) begin
         exp_ack = 5'b00001 << order[c];
         #1;
         checks++; if (fu_ack !== exp_ack) begin failures++; $display("FAIL contend_ack[%0d] got=%b exp=%b", c, fu_ack, exp_ack); end
         step();
         checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL contend_valid[%0d] got=%b exp=1", c, cdb_valid); end
         checks++; if (cdb_rob_tag !== TAG_W'(10 + order[c])) begin failures++; $display("FAIL contend_tag[%0d] got=%0d exp=%0d", c, cdb_rob_tag, 10 + order[c]); end
         checks++; if (cdb_value !== XLEN'(100 + order[c])) begin failures++; $display("FAIL contend_value[%0d] got=%0d exp=%0d", c, cdb_value, 100 + order[c]); end
         checks++; if (cdb_take_branch !== ((order[c] % 2) == 1)) begin failures++; $display("FAIL contend_branch[%0d] got=%b exp=%b", c, cdb_take_branch, (order[c] % 2) == 1); end
      end
      fu_done = '0;
   endtask

   task automatic test_hold();
      do_reset();
      fu_done = 5'b01010;
      #1;
      checks++; if (fu_ack !== 5'b00010) begin failures++; $display("FAIL hold_first_ack got=%b exp=%b", fu_ack, 5'b00010); end
      step();
      fu_done = 5'b01000;
      checks++; if (cdb_rob_tag !== 5'd11) begin failures++; $display("FAIL hold_first_tag got=%0d exp=11", cdb_rob_tag); end
      #1;
      checks++; if (fu_ack !== 5'b01000) begin failures++; $display("FAIL hold_second_ack got=%b exp=%b", fu_ack, 5'b01000); end
      step();
      fu_done = 5'b00000;
      checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL hold_second_valid got=%b exp=1", cdb_valid); end
      checks++; if (cdb_rob_tag !== 5'd13) begin failures++; $display("FAIL hold_second_tag got=%0d exp=13", cdb_rob_tag); end
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL hold_idle_valid got=%b exp=0", cdb_valid); end
   endtask

   task automatic test_wrap();
      fu_done = 5'b10000;
      #1;
      checks++; if (fu_ack !== 5'b10000) begin failures++; $display("FAIL wrap_first_ack got=%b exp=%b", fu_ack, 5'b10000); end
      step();
      checks++; if (cdb_rob_tag !== 5'd14) begin failures++; $display("FAIL wrap_first_tag got=%0d exp=14", cdb_rob_tag); end
      fu_done = 5'b10001;
      #1;
      checks++; if (fu_ack !== 5'b00001) begin failures++; $display("FAIL wrap_zero_ack got=%b exp=%b", fu_ack, 5'b00001); end
      step();
      checks++; if (cdb_rob_tag !== 5'd10) begin failures++; $display("FAIL wrap_zero_tag got=%0d exp=10", cdb_rob_tag); end
      fu_done = 5'b10000;
      #1;
      checks++; if (fu_ack !== 5'b10000) begin failures++; $display("FAIL wrap_four_ack got=%b exp=%b", fu_ack, 5'b10000); end
      step();
      checks++; if (cdb_rob_tag !== 5'd14) begin failures++; $display("FAIL wrap_four_tag got=%0d exp=14", cdb_rob_tag); end
      fu_done = '0;
      step();
   endtask

   task automatic test_reset_mid();
      // Grant slot 2 so the pointer moves to 3 before reset.
      fu_done = 5'b00100;
      step();
      checks++; if (cdb_rob_tag !== 5'd12) begin failures++; $display("FAIL mid_pre_tag got=%0d exp=12", cdb_rob_tag); end
      set_slot(2, 5'd7, 32'd77, 1'b1);
      fu_done = 5'b10100;
      reset   = 1'b0;
      #1;
      checks++; if (fu_ack !== 5'b00000) begin failures++; $display("FAIL mid_reset_ack got=%b exp=%b", fu_ack, 5'b00000); end
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", cdb_valid); end
      checks++; if (cdb_rob_tag !== 5'd0) begin failures++; $display("FAIL mid_reset_tag got=%0d exp=0", cdb_rob_tag); end
      checks++; if (cdb_value !== 32'd0) begin failures++; $display("FAIL mid_reset_value got=%0d exp=0", cdb_value); end
      checks++; if (fu_ack !== 5'b00000) begin failures++; $display("FAIL mid_reset_ack_held got=%b exp=%b", fu_ack, 5'b00000); end
      reset = 1'b1;
      #1;
      checks++; if (fu_ack !== 5'b00100) begin failures++; $display("FAIL mid_release_ack got=%b exp=%b", fu_ack, 5'b00100); end
      step();
      fu_done = 5'b10000;
      checks++; if (cdb_rob_tag !== 5'd7) begin failures++; $display("FAIL mid_release_tag got=%0d exp=7", cdb_rob_tag); end
      checks++; if (cdb_value !== 32'd77) begin failures++; $display("FAIL mid_release_value got=%0d exp=77", cdb_value); end
      checks++; if (cdb_take_branch !== 1'b1) begin failures++; $display("FAIL mid_release_branch got=%b exp=1", cdb_take_branch); end
      #1;
      checks++; if (fu_ack !== 5'b10000) begin failures++; $display("FAIL mid_next_ack got=%b exp=%b", fu_ack, 5'b10000); end
      step();
      fu_done = '0;
      checks++; if (cdb_rob_tag !== 5'd14) begin failures++; $display("FAIL mid_next_tag got=%0d exp=14", cdb_rob_tag); end
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b0;
      fu_done        = '0;
      fu_rob_tag     = '0;
      fu_value       = '0;
      fu_take_branch = '0;
      test_reset();
      test_single();
      test_contention();
      test_hold();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
